fft32_sdf_ctrl: RTL and testbench
=================================

# fft32_sdf_ctrl

Sequencing controller for the 32-point radix-2 single-path-delay-feedback (SDF) FFT pipeline. It accepts the input sample stream, generates the pipeline advance strobe and the per-stage butterfly/fill selects, and generates the twiddle ROM addresses for stages 1–4 (stage-4 ROM holds W0/W8 of W32). It also tags output samples with valid, frame-start and bit-reversed bin index, and drains the pipeline after the final frame.

## Interface
- BF_LAT, 1, register cycles added by each stage's butterfly/twiddle path after its delay line (legal 1–3)
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_valid  in  1  input sample present this cycle
- i_last  in  1  qualifies i_valid: final sample of final frame
- o_in_ready  out  1  controller accepts samples (low during FLUSH)
- o_adv  out  1  pipeline advance enable: all delay lines/registers shift only when high
- o_bf_en  out  5  bit s-1 = stage s in butterfly phase (1) or fill/twiddle phase (0)
- o_tw_addr1  out  4  stage-1 ROM address, index k of W32^k
- o_tw_addr2  out  3  stage-2 ROM address, W32^(2k)
- o_tw_addr3  out  2  stage-3 ROM address, W32^(4k)
- o_tw_addr4  out  1  stage-4 ROM address, W32^(8k)
- o_out_valid  out  1  pipeline output is a real FFT result
- o_frame_start  out  1  with o_out_valid: first output of a frame
- o_out_k  out  5  frequency bin of current output

## Operation
- States: IDLE, RUN, FLUSH. Reset → IDLE.
- IDLE: o_in_ready=1. Accepted i_valid → RUN. The sample is processed the same cycle.
- RUN: o_adv = i_valid. o_in_ready=1.
- Accepted sample with i_last=1 and in_cnt==31 → FLUSH. i_last with in_cnt≠31 is ignored.
- FLUSH: o_adv=1 every cycle; o_in_ready=0; i_valid ignored.
- Real-sample tracker: shift register v[0..TOT], TOT=31+5·BF_LAT (36 at default). Shifts on o_adv; v[0] = accepted real sample.
- When v is all zero in FLUSH → IDLE.
- Stage input offsets: L1=0, L(s+1)=L(s)+D(s)+BF_LAT, D(s)=32>>s (16,8,4,2,1).
- Stage s starts when v[L(s)] is first 1. Sticky start flag; cleared on return to IDLE.
- Per-stage counter c_s, 5-bit, wraps 31→0. Increments on every o_adv once started, including bubbles during drain.
- o_bf_en[s-1] = c_s[5-s].
- Twiddle address for s=1..4: bf_en ? 0 : c_s[4-s:0]. Stage 5 has no ROM.
- in_cnt: 5-bit count of accepted samples, wraps per frame.
- Output counter out_cnt: 5-bit, increments on o_out_valid.
- o_out_valid = o_adv & v[TOT].
- o_frame_start = o_out_valid & out_cnt==0.
- o_out_k = bit-reverse(out_cnt).
- Back-to-back frames in RUN need no gap. Gaps (i_valid=0) freeze all counters and v.

## Timing
- Reset values: state IDLE; v, c_s, in_cnt, out_cnt, start flags = 0.
- Reset outputs: o_in_ready=1, o_adv=0, o_bf_en=0, all o_tw_addr=0, o_out_valid=0, o_frame_start=0, o_out_k=0.
- o_adv, o_in_ready, o_out_valid: combinational from state, registers and i_valid. Same-cycle with accepted input.
- o_bf_en and o_tw_addr*: combinational from c_s. Valid in the cycle the corresponding stage advances.
- Latency: input sample n of a frame emerges after TOT advances (36 at default). With no gaps, sample 0 in at cycle t gives output at t+36.
- Reset is sampled every edge. Assertion mid-RUN/FLUSH aborts all frames. No output valid until fresh input.
- Last sample accepted (i_last) then next cycle FLUSH. Exactly TOT further cycles drain, then IDLE.

## Test plan
- Single frame, continuous, i_valid cycles 0–31, i_last at 31:
  - FLUSH at cycle 32, IDLE at cycle 68.
  - o_out_valid cycles 36–67.
  - o_out_k = 0,16,8,24,4,20,…,31; o_frame_start only at 36.
- Same stimulus, stage 1:
  - o_bf_en[0]=1 cycles 16–31.
  - o_tw_addr1=0 cycles 16–31; =0..15 cycles 32–47.
  - o_tw_addr4 toggles 0,1 on cycles where o_bf_en[3]=0, starting cycle 31.
- Two back-to-back frames with i_last on sample 63: 64 contiguous outputs, o_frame_start at cycles 36 and 68.
- i_valid gaps, one bubble every 3rd cycle, one frame:
  - counters and o_tw_addr* hold during gaps.
  - Output sequence identical to the continuous case; 32 valid outputs.
- i_last at in_cnt=10: ignored; remains RUN; o_in_ready stays 1.
- i_rst_n low for one cycle at cycle 50 of the two-frame test: next cycle IDLE, all outputs at reset values, no further o_out_valid.

Source files
------------

// File: rtl/fft32_sdf_ctrl.sv
// Purpose: sequencing controller for a 32-point radix-2 SDF FFT pipeline (advance, butterfly/fill selects, twiddle addresses, output tagging, drain).
// Latency: a sample accepted in cycle t is reported on the output tags after TOT = 31 + 5*BF_LAT pipeline advances (t+36 at default with no gaps).
// Backpressure: none inside the pipe; input bubbles freeze everything, and o_in_ready drops only while the last frame drains.
//
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_valid, i_last         input sample strobe; i_last marks the final sample of the final frame
//   o_in_ready              samples accepted (low while flushing)
//   o_adv                   pipeline-wide shift enable
//   o_bf_en[4:0]            per-stage butterfly (1) / fill-twiddle (0) select, bit s-1 = stage s
//   o_tw_addr1..4           twiddle ROM addresses for stages 1..4
//   o_out_valid, o_frame_start, o_out_k   output sample tags (bin index is bit-reversed order)
module fft32_sdf_ctrl #(
   parameter int BF_LAT = 1
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_valid,
   input  logic       i_last,
   output logic       o_in_ready,
   output logic       o_adv,
   output logic [4:0] o_bf_en,
   output logic [3:0] o_tw_addr1,
   output logic [2:0] o_tw_addr2,
   output logic [1:0] o_tw_addr3,
   output logic       o_tw_addr4,
   output logic       o_out_valid,
   output logic       o_frame_start,
   output logic [4:0] o_out_k
);

   // Total pipeline depth and the input tap of each stage inside the real-sample tracker.
   localparam int TOT = 31 + 5 * BF_LAT;
   localparam int L1  = 0;
   localparam int L2  = L1 + 16 + BF_LAT;
   localparam int L3  = L2 + 8 + BF_LAT;
   localparam int L4  = L3 + 4 + BF_LAT;
   localparam int L5  = L4 + 2 + BF_LAT;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t       state, state_nxt;
   logic [TOT:1] v_q;            // v[k] = a real sample sits k advances into the pipe
   logic [TOT-1:0] v_all;        // v[0] is the sample accepted this cycle
   logic         accept;
   logic         to_idle;
   logic [4:0]   started_q;
   logic [4:0]   start_now;
   logic [4:0]   c_q [5];
   logic [4:0]   in_cnt;
   logic [4:0]   out_cnt;
   logic         unused_bits;

   assign accept = (state != FLUSH) && i_valid;
   assign v_all  = {v_q[TOT-1:1], accept};

   // A stage counts from the advance on which its first real sample reaches its input.
   assign start_now = started_q | {v_all[L5], v_all[L4], v_all[L3], v_all[L2], v_all[L1]};

   always_comb begin
      state_nxt  = state;
      o_in_ready = 1'b1;
      o_adv      = i_valid;
      to_idle    = 1'b0;
      case (state)
         IDLE: begin
            if (i_valid) state_nxt = RUN;
         end
         RUN: begin
            // i_last only counts on the frame's final sample
            if (i_valid && i_last && (in_cnt == 5'd31)) state_nxt = FLUSH;
         end
         FLUSH: begin
            o_in_ready = 1'b0;
            o_adv      = 1'b1;
            // Leave once this advance empties the tracker (only v[TOT] may still be set).
            if (v_q[TOT-1:1] == '0) begin
               state_nxt = IDLE;
               to_idle   = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         v_q       <= '0;
         started_q <= '0;
         in_cnt    <= '0;
         out_cnt   <= '0;
         for (int s = 0; s < 5; s++) c_q[s] <= '0;
      end else begin
         state <= state_nxt;
         if (o_adv) v_q <= v_all;
         if (to_idle) begin
            // Realign every stage phase for the next frame sequence.
            started_q <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            for (int s = 0; s < 5; s++) c_q[s] <= '0;
         end else begin
            if (o_adv) begin
               started_q <= start_now;
               for (int s = 0; s < 5; s++)
                  if (start_now[s]) c_q[s] <= c_q[s] + 5'd1;
            end
            if (accept)      in_cnt  <= in_cnt + 5'd1;
            if (o_out_valid) out_cnt <= out_cnt + 5'd1;
         end
      end
   end

   // Stage s butterflies during the upper half of each 2*D(s) window.
   assign o_bf_en[0] = c_q[0][4];
   assign o_bf_en[1] = c_q[1][3];
   assign o_bf_en[2] = c_q[2][2];
   assign o_bf_en[3] = c_q[3][1];
   assign o_bf_en[4] = c_q[4][0];

   assign o_tw_addr1 = o_bf_en[0] ? 4'd0 : c_q[0][3:0];
   assign o_tw_addr2 = o_bf_en[1] ? 3'd0 : c_q[1][2:0];
   assign o_tw_addr3 = o_bf_en[2] ? 2'd0 : c_q[2][1:0];
   assign o_tw_addr4 = o_bf_en[3] ? 1'b0 : c_q[3][0];

   assign o_out_valid   = o_adv && v_q[TOT];
   assign o_frame_start = o_out_valid && (out_cnt == 5'd0);
   assign o_out_k       = {out_cnt[0], out_cnt[1], out_cnt[2], out_cnt[3], out_cnt[4]};

   // Upper counter bits above each stage's period carry no information.
   assign unused_bits = ^{c_q[1][4], c_q[2][4:3], c_q[3][4:2], c_q[4][4:1]};

endmodule

// File: tb/tb_fft32_sdf_ctrl.sv
// Directed bench for fft32_sdf_ctrl: reset values, single frame, back-to-back frames,
// input bubbles with a stray i_last, and a mid-run reset.
module tb_fft32_sdf_ctrl;

   logic       clk;
   logic       rst_n;
   logic       i_valid;
   logic       i_last;
   logic       o_in_ready;
   logic       o_adv;
   logic [4:0] o_bf_en;
   logic [3:0] o_tw_addr1;
   logic [2:0] o_tw_addr2;
   logic [1:0] o_tw_addr3;
   logic       o_tw_addr4;
   logic       o_out_valid;
   logic       o_frame_start;
   logic [4:0] o_out_k;

   int vectors = 0;
   int errors  = 0;

   fft32_sdf_ctrl #(.BF_LAT(1)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_valid       (i_valid),
      .i_last        (i_last),
      .o_in_ready    (o_in_ready),
      .o_adv         (o_adv),
      .o_bf_en       (o_bf_en),
      .o_tw_addr1    (o_tw_addr1),
      .o_tw_addr2    (o_tw_addr2),
      .o_tw_addr3    (o_tw_addr3),
      .o_tw_addr4    (o_tw_addr4),
      .o_out_valid   (o_out_valid),
      .o_frame_start (o_frame_start),
      .o_out_k       (o_out_k)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] brev(input int x);
      logic [4:0] a;
      logic [4:0] r;
      a = x[4:0];
      for (int i = 0; i < 5; i++) r[i] = a[4-i];
      return r;
   endfunction

   // One clock cycle: inputs change just after the rising edge, outputs are sampled mid-cycle.
   task automatic step(input logic v, input logic l, input logic r);
      @(posedge clk);
      #1;
      i_valid = v;
      i_last  = l;
      rst_n   = r;
      #3;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_ready"}, o_in_ready, 1);
      chk({tag, "_adv"},   o_adv, 0);
      chk({tag, "_bf"},    o_bf_en, 0);
      chk({tag, "_tw1"},   o_tw_addr1, 0);
      chk({tag, "_tw2"},   o_tw_addr2, 0);
      chk({tag, "_tw3"},   o_tw_addr3, 0);
      chk({tag, "_tw4"},   o_tw_addr4, 0);
      chk({tag, "_oval"},  o_out_valid, 0);
      chk({tag, "_fs"},    o_frame_start, 0);
      chk({tag, "_k"},     o_out_k, 0);
   endtask

   initial begin
      logic [6:0] tt;
      int c4, sent, nadv, nout, g, nout2;
      logic vv, ll;
      logic [4:0] c1;

      rst_n   = 1'b0;
      i_valid = 1'b0;
      i_last  = 1'b0;

      // ---- reset values
      step(0, 0, 0);
      step(0, 0, 0);
      chk_reset_outs("rst");
      step(0, 0, 1);
      step(0, 0, 1);
      chk_reset_outs("rst_rel");

      // ---- single continuous frame, i_last on cycle 31
      for (int t = 0; t < 70; t++) begin
         step(t < 32, t == 31, 1);
         chk("s1_ready", o_in_ready, (t < 32 || t >= 68));
         chk("s1_adv",   o_adv, (t < 68));
         chk("s1_oval",  o_out_valid, (t >= 36 && t <= 67));
         chk("s1_fs",    o_frame_start, (t == 36));
         if (t >= 36 && t <= 67) chk("s1_k", o_out_k, brev(t - 36));
         if (t < 68) begin
            tt = t[6:0];
            chk("s1_bf0", o_bf_en[0], tt[4]);
            chk("s1_tw1", o_tw_addr1, tt[4] ? 4'd0 : tt[3:0]);
            c4 = (t >= 31) ? (t - 31) % 32 : 0;
            chk("s1_bf3", o_bf_en[3], c4[1]);
            chk("s1_tw4", o_tw_addr4, c4[1] ? 1'b0 : c4[0]);
         end
      end

      // ---- two back-to-back frames, i_last on sample 63
      nout2 = 0;
      for (int t = 0; t < 106; t++) begin
         step(t < 64, t == 63, 1);
         chk("b2b_ready", o_in_ready, (t < 64 || t >= 100));
         chk("b2b_oval",  o_out_valid, (t >= 36 && t <= 99));
         chk("b2b_fs",    o_frame_start, (t == 36 || t == 68));
         if (t >= 36 && t <= 99) chk("b2b_k", o_out_k, brev((t - 36) % 32));
         if (o_out_valid) nout2++;
      end
      chk("b2b_nout", nout2, 64);

      // ---- bubble every third cycle, stray i_last on sample 10
      sent = 0; nadv = 0; nout = 0; g = 0;
      while (sent < 32 && g < 200) begin
         vv = (g % 3 != 2);
         ll = vv && (sent == 10 || sent == 31);
         step(vv, ll, 1);
         c1 = nadv[4:0];
         chk("gap_ready", o_in_ready, 1);
         chk("gap_adv",   o_adv, vv);
         chk("gap_bf0",   o_bf_en[0], c1[4]);
         chk("gap_tw1",   o_tw_addr1, c1[4] ? 4'd0 : c1[3:0]);
         if (o_out_valid) begin
            chk("gap_k",  o_out_k, brev(nout));
            chk("gap_fs", o_frame_start, (nout == 0));
            nout++;
         end
         if (vv) begin
            sent++;
            nadv++;
         end
         g++;
      end
      chk("gap_sent", sent, 32);
      for (int f = 0; f < 36; f++) begin
         step(0, 0, 1);
         c1 = nadv[4:0];
         chk("gap_fl_ready", o_in_ready, 0);
         chk("gap_fl_adv",   o_adv, 1);
         chk("gap_fl_tw1",   o_tw_addr1, c1[4] ? 4'd0 : c1[3:0]);
         if (o_out_valid) begin
            chk("gap_k",  o_out_k, brev(nout));
            chk("gap_fs", o_frame_start, (nout == 0));
            nout++;
         end
         nadv++;
      end
      step(0, 0, 1);
      chk("gap_idle_ready", o_in_ready, 1);
      chk("gap_idle_oval",  o_out_valid, 0);
      chk("gap_nout", nout, 32);

      // ---- two-frame stream with reset pulse on cycle 50
      for (int t = 0; t < 112; t++) begin
         step((t <= 50), 0, (t != 50));
         if (t <= 50) begin
            chk("mr_oval", o_out_valid, (t >= 36));
            if (t >= 36) chk("mr_k", o_out_k, brev(t - 36));
         end else begin
            chk_reset_outs("mr_post");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
